pri_arb_ctrl: RTL and testbench



---
 rtl/pri_arb_ctrl_pkg.sv | 16 +
 rtl/pri_arb_ctrl_if.sv | 32 +++
 rtl/pri_arb_ctrl_rr_pri_sel.sv | 67 ++++++
 rtl/pri_arb_ctrl.sv | 129 ++++++++++++
 tb/tb_pri_arb_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/pri_arb_ctrl_pkg.sv
// pri_arb_pkg: shared constants and types for the pri_arb_ctrl arbiter slice.
//   N     : number of requesters (fixed at 8)
//   ID_W  : width of a requester index (fixed at 3 for N=8)
//   arb_state_e : arbiter FSM states (IDLE, GRANT, GAP)
package pri_arb_pkg;

  localparam int N    = 8;
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pri_arb_ctrl_if.sv
// pri_arb_ctrl_if: request/grant bundle between the requesting blocks and
// the arbiter.
//   req       : level requests, one bit per requester
//   mode      : 0 = fixed priority, 1 = round-robin
//   gnt       : one-hot grant (zero when nothing granted)
//   gnt_id    : index of the granted requester, meaningful while gnt_valid=1
//   gnt_valid : |gnt
//   idle      : arbiter sits in IDLE
//   timeout   : one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface pri_arb_ctrl_if;
  import pri_arb_pkg::*;

  logic [N-1:0]    req;
  logic            mode;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_valid;
  logic            idle;
  logic            timeout;

  modport master (
    output req, mode,
    input  gnt, gnt_id, gnt_valid, idle, timeout
  );

  modport slave (
    input  req, mode,
    output gnt, gnt_id, gnt_valid, idle, timeout
  );

endinterface

// File: rtl/pri_arb_ctrl_rr_pri_sel.sv
// rr_pri_sel: combinational winner selector.
//   req     : request vector
//   last_id : index of the most recently released grant
//   mode    : 0 = fixed (index N-1 highest), 1 = round-robin from last_id-1
//   sel     : one-hot winner (zero when req is zero)
//   sel_id  : winner index
//   any     : at least one request present
// The request vector is rotated so that the first index to search lands on
// bit N-1, a plain highest-index-first chain picks a bit, and the chosen
// position is rotated back into the original index space.
module rr_pri_sel
  import pri_arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_id,
  input  logic            mode,
  output logic [N-1:0]    sel,
  output logic [ID_W-1:0] sel_id,
  output logic            any
);

  logic [ID_W-1:0] shift_s;
  logic [N-1:0]    rot_s;
  logic [ID_W-1:0] pos_s;
  logic            hit_s;

  // rotation amount: zero in fixed mode so the search order is N-1..0
  always_comb begin
    shift_s = {ID_W{1'b0}};
    if (mode) begin
      shift_s = last_id;
    end else begin
      shift_s = {ID_W{1'b0}};
    end
  end

  // rotated view: bit j holds req[(j + shift) mod N]; ID_W-bit add wraps mod N
  always_comb begin
    rot_s = {N{1'b0}};
    for (int j = 0; j < N; j++) begin
      rot_s[j] = req[ID_W'(j) + shift_s];
    end
  end

  // highest-index-first priority chain over the rotated vector
  always_comb begin
    hit_s = 1'b0;
    pos_s = {ID_W{1'b0}};
    for (int j = N - 1; j >= 0; j--) begin
      pos_s = (rot_s[j] && !hit_s) ? ID_W'(j) : pos_s;
      hit_s = hit_s | rot_s[j];
    end
  end

  // rotate the winning position back and build the one-hot select
  always_comb begin
    sel_id = pos_s + shift_s;
    any    = hit_s;
    sel    = {N{1'b0}};
    if (hit_s) begin
      sel[sel_id] = 1'b1;
    end else begin
      sel = {N{1'b0}};
    end
  end

endmodule

// File: rtl/pri_arb_ctrl.sv
// pri_arb_ctrl: sequential 8-way arbiter with registered one-hot grants.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : pri_arb_ctrl_if slave modport (req/mode in; gnt, gnt_id,
//         gnt_valid, idle, timeout out -- all outputs registered)
// A grant is held until its requester drops req or, when MAX_HOLD is
// non-zero, until it has been held MAX_HOLD cycles. Every release is
// followed by exactly one all-zero turnaround cycle (GAP).
module pri_arb_ctrl
  import pri_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  pri_arb_ctrl_if.slave        bus
);

  localparam bit              TO_EN     = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b0}} : HOLD_W'(MAX_HOLD - 1);

  arb_state_e      state_r, state_s;
  logic [N-1:0]    gnt_r, gnt_s;
  logic [ID_W-1:0] gnt_id_r, gnt_id_s;
  logic            gnt_valid_r, gnt_valid_s;
  logic            idle_r, idle_s;
  logic            timeout_r, timeout_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [ID_W-1:0] last_id_r, last_id_s;

  logic [N-1:0]    sel_s;
  logic [ID_W-1:0] sel_id_s;
  logic            any_s;

  rr_pri_sel u_sel (
    .req     (bus.req),
    .last_id (last_id_r),
    .mode    (bus.mode),
    .sel     (sel_s),
    .sel_id  (sel_id_s),
    .any     (any_s)
  );

  // next-state and next-output computation
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    gnt_id_s    = gnt_id_r;
    gnt_valid_s = gnt_valid_r;
    idle_s      = idle_r;
    timeout_s   = 1'b0;
    hold_cnt_s  = hold_cnt_r;
    last_id_s   = last_id_r;
    case (state_r)
      IDLE, GAP: begin
        // IDLE and GAP arbitrate identically; only req seen now matters
        if (any_s) begin
          state_s     = GRANT;
          gnt_s       = sel_s;
          gnt_id_s    = sel_id_s;
          gnt_valid_s = 1'b1;
          idle_s      = 1'b0;
          hold_cnt_s  = {HOLD_W{1'b0}};
        end else begin
          state_s     = IDLE;
          gnt_s       = {N{1'b0}};
          gnt_valid_s = 1'b0;
          idle_s      = 1'b1;
          hold_cnt_s  = {HOLD_W{1'b0}};
        end
      end
      GRANT: begin
        // a dropped request wins over a coincident timeout (no pulse)
        if (!bus.req[gnt_id_r] || (TO_EN && (hold_cnt_r == HOLD_LAST))) begin
          state_s     = GAP;
          gnt_s       = {N{1'b0}};
          gnt_valid_s = 1'b0;
          idle_s      = 1'b0;
          last_id_s   = gnt_id_r;
          hold_cnt_s  = {HOLD_W{1'b0}};
          timeout_s   = bus.req[gnt_id_r];
        end else begin
          hold_cnt_s  = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_s       = {N{1'b0}};
        gnt_id_s    = {ID_W{1'b0}};
        gnt_valid_s = 1'b0;
        idle_s      = 1'b1;
        hold_cnt_s  = {HOLD_W{1'b0}};
        last_id_s   = {ID_W{1'b0}};
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      gnt_r       <= {N{1'b0}};
      gnt_id_r    <= {ID_W{1'b0}};
      gnt_valid_r <= 1'b0;
      idle_r      <= 1'b1;
      timeout_r   <= 1'b0;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      last_id_r   <= {ID_W{1'b0}};
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gnt_id_r    <= gnt_id_s;
      gnt_valid_r <= gnt_valid_s;
      idle_r      <= idle_s;
      timeout_r   <= timeout_s;
      hold_cnt_r  <= hold_cnt_s;
      last_id_r   <= last_id_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.idle      = idle_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_pri_arb_ctrl.sv
// Directed-vector bench for pri_arb_ctrl with a scoreboard queue: each step
// drives inputs before a rising edge and queues the outputs expected after
// it; a monitor pops one entry per edge and compares.
module tb_pri_arb_ctrl;

  typedef struct {
    logic [7:0] gnt;
    logic       idle;
    logic       to;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  exp_t q[$];

  pri_arb_ctrl_if bus();

  pri_arb_ctrl #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic md,
                      input logic [7:0] eg, input logic ei, input logic et,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.mode = md;
    e.gnt  = eg;
    e.idle = ei;
    e.to   = et;
    e.name = nm;
    q.push_back(e);
  endtask

  // monitor: one expected entry per rising edge, sampled 1 time unit later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".gnt"},       bus.gnt,                 e.gnt);
        chk({e.name, ".gnt_valid"}, {7'd0, bus.gnt_valid},   {7'd0, |e.gnt});
        chk({e.name, ".idle"},      {7'd0, bus.idle},        {7'd0, e.idle});
        chk({e.name, ".timeout"},   {7'd0, bus.timeout},     {7'd0, e.to});
        if (|e.gnt) begin
          chk({e.name, ".gnt_id"}, {5'd0, bus.gnt_id}, {5'd0, enc(e.gnt)});
        end
      end
    end
  end

  initial begin
    logic [7:0] oh;
    logic [7:0] nx;
    total    = 0;
    passed   = 0;
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.mode = 1'b0;

    // reset held with all requests high, then first grant to index 7
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, "rst_hold0");
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, "rst_hold1");
    step(1'b0, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b0, "first_grant");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "first_gap");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "first_idle");

    // fixed priority: 5 beats 2; after release one gap then 2
    step(1'b0, 8'h24, 1'b0, 8'h20, 1'b0, 1'b0, "fix_win5");
    step(1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, "fix_gap");
    step(1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0, "fix_win2");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "fix_gap2");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "fix_idle");

    // reset clears last_id, then round-robin sweep 7..0 and back to 7
    step(1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "rr_rst");
    step(1'b0, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b0, "rr_first");
    for (int i = 7; i >= 0; i--) begin
      oh = 8'h01 << i;
      nx = 8'h01 << ((i + 7) % 8);
      step(1'b0, 8'hFF,      1'b1, oh,    1'b0, 1'b0, "rr_hold");
      step(1'b0, 8'hFF & ~oh, 1'b1, 8'h00, 1'b0, 1'b0, "rr_gap");
      step(1'b0, 8'hFF,      1'b1, nx,    1'b0, 1'b0, "rr_next");
    end
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "rr_end_gap");
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "rr_end_idle");

    // timeout in round-robin: sole requester 3 held 16 cycles, re-granted
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h08, 1'b1, 8'h08, 1'b0, 1'b0, "to_hold");
    end
    step(1'b0, 8'h08, 1'b1, 8'h00, 1'b0, 1'b1, "to_pulse");
    step(1'b0, 8'h08, 1'b1, 8'h08, 1'b0, 1'b0, "to_regrant");
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "to_gap");
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "to_idle");

    // release on the same cycle the hold limit is reached: no timeout
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0, "rel_hold");
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "rel_no_to");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "rel_idle");

    // reset mid-grant, then re-grant one cycle after release of reset
    step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, "mid_grant");
    step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, "mid_hold");
    step(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, "mid_rst");
    step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, "mid_regrant");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "mid_gap");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "mid_idle");

    // round-robin from last_id=4: search 3,2,1,0 first so 0 beats 5 and 4
    step(1'b0, 8'h31, 1'b1, 8'h01, 1'b0, 1'b0, "rr4_win0");
    step(1'b0, 8'h30, 1'b1, 8'h00, 1'b0, 1'b0, "rr4_gap");
    step(1'b0, 8'h30, 1'b1, 8'h20, 1'b0, 1'b0, "rr0_win5");
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "rr0_gap");
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "rr0_idle");

    @(posedge clk);
    #3;
    chk("drain", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
